f2i_arbiter: RTL and testbench
==============================

// Module: f2i_arbiter
// PURPOSE
//  Shares one combinational f2i float->int converter between NREQ requesters.
//  - Round-robin arbitration over valid/ready request channels.
//  - Sequences each conversion through a small FSM and registers the result.
//  - Returns the result and its exception flags on one valid/ready response channel, tagged with the requester id.
//  - Keeps sticky per-requester invalid/p_lost flags, in the style of an FP status register.
// PARAMETERS
//  NREQ  2  number of requesters (2..8)
//  IDW   1  width of the requester id; must be >= clog2(NREQ), and at least 1
// PORTS
//  clk            in   1        clock; all state updates on the rising edge
//  rst            in   1        synchronous reset, active-high
//  req_valid      in   NREQ     request i presents an operand
//  req_ready      out  NREQ     one-hot grant; a handshake happens when valid&ready
//  req_a          in   NREQ*32  IEEE-754 single operands; requester i uses bits [32i+31:32i]
//  rsp_valid      out  1        result available
//  rsp_ready      in   1        consumer accepts the result
//  rsp_id         out  IDW      requester that owns the result
//  rsp_d          out  32       integer result, taken unmodified from f2i.d
//  rsp_p_lost     out  1        precision lost
//  rsp_denorm     out  1        operand was denormalized
//  rsp_invalid    out  1        inf, NaN or out of range
//  flag_clr       in   NREQ     clears the sticky flags of requester i
//  sticky_invalid out  NREQ     OR of rsp_invalid over delivered results, per requester
//  sticky_p_lost  out  NREQ     OR of rsp_p_lost over delivered results, per requester
// BEHAVIOUR
//  Reset (sync):
//   - state=IDLE and rr_ptr=0.
//   - All outputs are 0: rsp_*, sticky_*, req_ready.
//   - Reset mid-operation drops the in-flight operand and result silently; no response is emitted.
//  FSM states: IDLE, CONV, RESP.
//   - IDLE: req_ready = one-hot grant of the arbiter (0 if no req_valid).
//     On a handshake: latch operand into a_reg and id into id_reg; go to CONV.
//   - CONV: req_ready=0. f2i evaluates a_reg. Register d, p_lost, denorm and invalid into the rsp_* registers. Go to RESP.
//   - RESP: rsp_valid=1. rsp_* stay stable until rsp_ready.
//     On rsp_ready: update sticky flags for rsp_id.
//     If a request is also pending, req_ready = grant in this same cycle; accept it and go to CONV (back-to-back).
//     Otherwise go to IDLE.
//     Without rsp_ready: stay in RESP with req_ready=0.
//  Latency and throughput:
//   - Operand accepted at cycle N -> rsp_valid high from cycle N+2.
//   - Peak throughput is 1 conversion per 2 cycles.
//  Arbitration:
//   - Search starts at rr_ptr upward, wrapping modulo NREQ; the first valid requester wins.
//   - On acceptance, rr_ptr = grantee+1, wrapping to 0 after NREQ-1.
//   - req_ready is combinational from req_valid, state and rr_ptr. It never depends on req_a.
//   - req_valid falling without a handshake is legal; it is never granted.
//  Sticky flags:
//   - On rsp handshake: sticky_*[rsp_id] |= rsp_*.
//   - flag_clr[i] zeroes sticky_*[i] in the next cycle.
//   - flag_clr[i] in the same cycle as a delivery to i: the clear wins over the prior value, but the new flag is still set.
//     sticky = rsp flag, not 0.
//  rsp_denorm is reported per response only; it is not sticky.
// STRUCTURE
//  Shared package fpu_pkg:
//   - FSM state encoding (IDLE, CONV, RESP).
//   - F32_W=32.
//   - Named IEEE-754 constants used by the bench: POS_INF=0x7F800000, QNAN=0x7FC00000.
//  Sub-module: reuse the existing f2i (ports a, d, p_lost, denorm, invalid), instantiated once and fed by a_reg.
//  Round-robin arbiter is inline logic, not a separate module.
// TESTING
//  1. Single request from req 0: req_a=0x41200000 (10.0) -> rsp_d=10, id=0, flags=0, rsp_valid at N+2.
//  2. Precision and sign: 0x40490FDB (3.14159) -> d=3, p_lost=1; 0xC1200000 (-10.0) -> d=0xFFFFFFF6, p_lost=0.
//  3. Exceptions: 0x7F800000 -> invalid=1; 0x00000001 -> denorm=1, d=0.
//     Afterwards sticky_invalid[id] stays 1 until flag_clr[id]; same-cycle clear+delivery leaves the new flag set.
//  4. Fairness: both requesters valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; one accept every 2 cycles.
//  5. Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable and req_ready=0 throughout; release -> back-to-back accept of the pending request.
//  6. Reset in CONV and in RESP -> next cycle all outputs 0, state IDLE, no stray response; the next request completes normally.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FP definitions for the f2i arbiter slice.
// FSM encoding and IEEE-754 single constants.
package fpu_pkg;

  localparam int F32_W = 32;

  localparam logic [F32_W-1:0] POS_INF = 32'h7F80_0000;
  localparam logic [F32_W-1:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    RESP
  } state_t;

endpackage

// File: rtl/f2i_arbiter_if.sv
// Request/response/flag bundle of the f2i arbiter.
// master = requesters and consumer, slave = arbiter.
interface f2i_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
);
  import fpu_pkg::*;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*F32_W-1:0] req_a;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [F32_W-1:0]      rsp_d;
  logic                  rsp_p_lost;
  logic                  rsp_denorm;
  logic                  rsp_invalid;
  logic [NREQ-1:0]       flag_clr;
  logic [NREQ-1:0]       sticky_invalid;
  logic [NREQ-1:0]       sticky_p_lost;

  modport master (
    output req_valid, req_a, rsp_ready, flag_clr,
    input  req_ready, rsp_valid, rsp_id, rsp_d,
    input  rsp_p_lost, rsp_denorm, rsp_invalid,
    input  sticky_invalid, sticky_p_lost
  );

  modport slave (
    input  req_valid, req_a, rsp_ready, flag_clr,
    output req_ready, rsp_valid, rsp_id, rsp_d,
    output rsp_p_lost, rsp_denorm, rsp_invalid,
    output sticky_invalid, sticky_p_lost
  );

endinterface

// File: rtl/f2i.sv
// Combinational float32 -> int32 converter, truncating toward zero.
// Out-of-range / inf / NaN saturate and raise invalid.
module f2i
  import fpu_pkg::*;
(
  input  logic [F32_W-1:0] a,
  output logic [F32_W-1:0] d,
  output logic             p_lost,
  output logic             denorm,
  output logic             invalid
);

  logic        sgn;
  logic [7:0]  ex;
  logic [22:0] man;
  logic [54:0] sh;
  logic [31:0] mag;

  always_comb begin
    sgn     = a[31];
    ex      = a[30:23];
    man     = a[22:0];
    d       = '0;
    p_lost  = 1'b0;
    denorm  = 1'b0;
    invalid = 1'b0;
    sh      = '0;
    mag     = '0;
    if (ex == 8'hFF) begin
      invalid = 1'b1;
      d = (sgn && man == '0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (ex == 8'h00) begin
      // a nonzero denormal truncates to 0, so its value is lost too
      denorm = |man;
      p_lost = |man;
    end else if (ex < 8'd127) begin
      p_lost = 1'b1;
    end else if (ex >= 8'd158) begin
      if (sgn && ex == 8'd158 && man == '0) begin
        d = 32'h8000_0000;
      end else begin
        invalid = 1'b1;
        d = sgn ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
    end else begin
      sh     = {31'b0, 1'b1, man} << (ex - 8'd127);
      mag    = sh[54:23];
      p_lost = |sh[22:0];
      d      = sgn ? -mag : mag;
    end
  end

endmodule

// File: rtl/f2i_arbiter.sv
// Round-robin share of one f2i converter between NREQ requesters,
// with registered tagged responses and sticky per-requester flags.
module f2i_arbiter
  import fpu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic          clk,
  input  logic          rst,
  f2i_arbiter_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   rr_nxt;
  logic [F32_W-1:0] a_reg;
  logic [IDW-1:0]   id_reg;

  logic             any_valid;
  logic [IDW-1:0]   gnt_id;
  logic [NREQ-1:0]  gnt_oh;
  logic             accept;
  logic             deliver;

  logic [F32_W-1:0] cv_d;
  logic             cv_pl;
  logic             cv_dn;
  logic             cv_inv;

  logic [F32_W-1:0] rsp_d_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_pl_q;
  logic             rsp_dn_q;
  logic             rsp_inv_q;
  logic [NREQ-1:0]  sinv_q;
  logic [NREQ-1:0]  spl_q;
  logic [NREQ-1:0]  sinv_nxt;
  logic [NREQ-1:0]  spl_nxt;

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  f2i u_f2i (
    .a       (a_reg),
    .d       (cv_d),
    .p_lost  (cv_pl),
    .denorm  (cv_dn),
    .invalid (cv_inv)
  );

  // first valid requester at or above rr_ptr, wrapping
  always_comb begin
    any_valid = 1'b0;
    gnt_id    = '0;
    gnt_oh    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!any_valid && bus.req_valid[wrap(int'(rr_ptr) + i)]) begin
        any_valid = 1'b1;
        gnt_id    = IDW'(wrap(int'(rr_ptr) + i));
        gnt_oh[wrap(int'(rr_ptr) + i)] = 1'b1;
      end
    end
    rr_nxt = IDW'(wrap(int'(gnt_id) + 1));
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = '0;
    accept        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = gnt_oh;
        accept        = any_valid;
        if (any_valid) state_nxt = CONV;
      end
      CONV: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          bus.req_ready = gnt_oh;
          accept        = any_valid;
          state_nxt     = any_valid ? CONV : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      bus.req_ready = '0;
      accept        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign deliver = (state == RESP) && bus.rsp_ready;

  // clear drops the old value; a same-cycle delivery still lands
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      sinv_nxt[i] = (bus.flag_clr[i] ? 1'b0 : sinv_q[i])
                  | (deliver && rsp_id_q == IDW'(i) && rsp_inv_q);
      spl_nxt[i]  = (bus.flag_clr[i] ? 1'b0 : spl_q[i])
                  | (deliver && rsp_id_q == IDW'(i) && rsp_pl_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      a_reg     <= '0;
      id_reg    <= '0;
      rsp_d_q   <= '0;
      rsp_id_q  <= '0;
      rsp_pl_q  <= 1'b0;
      rsp_dn_q  <= 1'b0;
      rsp_inv_q <= 1'b0;
      sinv_q    <= '0;
      spl_q     <= '0;
    end else begin
      if (accept) begin
        a_reg  <= bus.req_a[int'(gnt_id)*F32_W +: F32_W];
        id_reg <= gnt_id;
        rr_ptr <= rr_nxt;
      end
      if (state == CONV) begin
        rsp_d_q   <= cv_d;
        rsp_id_q  <= id_reg;
        rsp_pl_q  <= cv_pl;
        rsp_dn_q  <= cv_dn;
        rsp_inv_q <= cv_inv;
      end
      sinv_q <= sinv_nxt;
      spl_q  <= spl_nxt;
    end
  end

  assign bus.rsp_valid      = (state == RESP);
  assign bus.rsp_id         = rsp_id_q;
  assign bus.rsp_d          = rsp_d_q;
  assign bus.rsp_p_lost     = rsp_pl_q;
  assign bus.rsp_denorm     = rsp_dn_q;
  assign bus.rsp_invalid    = rsp_inv_q;
  assign bus.sticky_invalid = sinv_q;
  assign bus.sticky_p_lost  = spl_q;

endmodule

// File: tb/tb_f2i_arbiter.sv
// Directed bench for f2i_arbiter: conversions, flags,
// fairness, backpressure and mid-operation reset.
module tb_f2i_arbiter;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  f2i_arbiter_if #(.NREQ(2), .IDW(1)) bus ();

  f2i_arbiter #(.NREQ(2), .IDW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_d"}, bus.rsp_d, 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_flg"}, 32'({bus.rsp_p_lost, bus.rsp_denorm,
                            bus.rsp_invalid}), 32'd0);
    chk({tag, "_sinv"}, 32'(bus.sticky_invalid), 32'd0);
    chk({tag, "_spl"}, 32'(bus.sticky_p_lost), 32'd0);
  endtask

  // one isolated request: grant, N+2 latency, payload, delivery
  task automatic convert(input int id, input logic [31:0] a,
                         input logic [31:0] exp_d, input bit chk_d,
                         input bit epl, input bit edn, input bit einv,
                         input logic [1:0] clr);
    bus.req_valid[id] = 1'b1;
    bus.req_a[id*32 +: 32] = a;
    #1;
    chk("grant", 32'(bus.req_ready), 32'(1 << id));
    step();
    bus.req_valid[id] = 1'b0;
    chk("conv_vld", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("rsp_vld", 32'(bus.rsp_valid), 32'd1);
    chk("rsp_id", 32'(bus.rsp_id), 32'(id));
    if (chk_d) chk("rsp_d", bus.rsp_d, exp_d);
    chk("rsp_flg", 32'({bus.rsp_p_lost, bus.rsp_denorm,
                        bus.rsp_invalid}), 32'({epl, edn, einv}));
    bus.rsp_ready = 1'b1;
    bus.flag_clr  = clr;
    step();
    bus.rsp_ready = 1'b0;
    bus.flag_clr  = '0;
    chk("done_vld", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.rsp_ready = 1'b0;
    bus.flag_clr  = '0;
    rst = 1'b1;
    repeat (3) step();
    chk_zero("reset");
    bus.req_valid = 2'b11;
    #1;
    chk("rst_gate", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // basic, precision, sign
    convert(0, 32'h4120_0000, 32'd10, 1'b1, 0, 0, 0, 2'b00);
    convert(1, 32'h4049_0FDB, 32'd3, 1'b1, 1, 0, 0, 2'b00);
    convert(0, 32'hC120_0000, 32'hFFFF_FFF6, 1'b1, 0, 0, 0, 2'b00);
    chk("spl_a", 32'(bus.sticky_p_lost), 32'd2);
    chk("sinv_a", 32'(bus.sticky_invalid), 32'd0);

    // exceptions and sticky behaviour
    convert(1, POS_INF, 32'd0, 1'b0, 0, 0, 1, 2'b00);
    chk("sinv_b", 32'(bus.sticky_invalid), 32'd2);
    convert(0, 32'h0000_0001, 32'd0, 1'b1, 1, 1, 0, 2'b00);
    chk("spl_b", 32'(bus.sticky_p_lost), 32'd3);
    convert(1, QNAN, 32'd0, 1'b0, 0, 0, 1, 2'b00);
    repeat (3) step();
    chk("sinv_hold", 32'(bus.sticky_invalid), 32'd2);
    bus.flag_clr = 2'b10;
    step();
    bus.flag_clr = '0;
    chk("sinv_clr", 32'(bus.sticky_invalid), 32'd0);
    chk("spl_clr", 32'(bus.sticky_p_lost), 32'd1);
    convert(0, 32'h4120_0000, 32'd10, 1'b1, 0, 0, 0, 2'b01);
    chk("spl_clrwin", 32'(bus.sticky_p_lost), 32'd0);
    convert(1, POS_INF, 32'd0, 1'b0, 0, 0, 1, 2'b10);
    chk("sinv_newset", 32'(bus.sticky_invalid), 32'd2);

    // fairness: rr_ptr is 0 after the req 1 accept above
    bus.req_a = {32'h4000_0000, 32'h3F80_0000};
    bus.req_valid = 2'b11;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("fair_rdy", 32'(bus.req_ready),
          (c % 2 == 0) ? (((c / 2) % 2 == 0) ? 32'd1 : 32'd2) : 32'd0);
      chk("fair_vld", 32'(bus.rsp_valid),
          (c % 2 == 0 && c >= 2) ? 32'd1 : 32'd0);
      if (c % 2 == 0 && c >= 2) begin
        chk("fair_id", 32'(bus.rsp_id), 32'(((c / 2) - 1) % 2));
        chk("fair_d", bus.rsp_d, 32'(((c / 2) - 1) % 2 + 1));
      end
      step();
    end
    bus.req_valid = '0;
    #1;
    chk("fair_last_id", 32'(bus.rsp_id), 32'd1);
    chk("fair_last_d", bus.rsp_d, 32'd2);
    chk("fair_last_rdy", 32'(bus.req_ready), 32'd0);
    step();
    bus.rsp_ready = 1'b0;
    chk("fair_idle", 32'(bus.rsp_valid), 32'd0);

    // backpressure with a pending request from req 1
    bus.req_a = {32'hC120_0000, 32'h4120_0000};
    bus.req_valid = 2'b01;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'd1);
    step();
    bus.req_valid = 2'b10;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_vld", 32'(bus.rsp_valid), 32'd1);
      chk("bp_d", bus.rsp_d, 32'd10);
      chk("bp_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_rdy", 32'(bus.req_ready), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("b2b_rdy", 32'(bus.req_ready), 32'd2);
    step();
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    chk("b2b_conv", 32'(bus.rsp_valid), 32'd0);
    step();
    chk("b2b_vld", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_id", 32'(bus.rsp_id), 32'd1);
    chk("b2b_d", bus.rsp_d, 32'hFFFF_FFF6);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // reset while in CONV
    bus.req_a = {32'h4000_0000, 32'h4000_0000};
    bus.req_valid = 2'b01;
    step();
    bus.req_valid = '0;
    chk("rc_conv", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero("rst_conv");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rc_stray", 32'(bus.rsp_valid), 32'd0);
    end

    // reset while in RESP
    bus.req_valid = 2'b10;
    step();
    bus.req_valid = '0;
    step();
    chk("rr_vld", 32'(bus.rsp_valid), 32'd1);
    chk("rr_d", bus.rsp_d, 32'd2);
    rst = 1'b1;
    bus.req_valid = 2'b10;
    #1;
    chk("rr_gate", 32'(bus.req_ready), 32'd0);
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    chk_zero("rst_resp");
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr_stray", 32'(bus.rsp_valid), 32'd0);
    end

    convert(1, 32'h4120_0000, 32'd10, 1'b1, 0, 0, 0, 2'b00);
    convert(0, 32'hC120_0000, 32'hFFFF_FFF6, 1'b1, 0, 0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
